pixel_fb_writer: RTL and testbench
==================================

Name: pixel_fb_writer

Overview:
- Consumer end of the draw-sequencer pixel stream: accepts (x, y, colour) pixels over a valid/ready handshake and buffers them in a small FIFO.
- Converts each pixel to a linear framebuffer address and issues single-cycle writes to the 160x120, 3-bit-colour framebuffer RAM. Write issue is gated by the memory arbiter's busy flag.
- Also provides a whole-screen clear sequence and a drop counter for clipped pixels.
- Sits between the board/score draw sequencer and the VGA framebuffer memory.

Parameters:
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, minimum 2.
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- BG_COLOUR, 3'b000, colour written by the clear sequence.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  upstream pixel present.
- pix_ready  out  1  FIFO can accept a pixel this cycle.
- pix_x  in  8  pixel x coordinate.
- pix_y  in  7  pixel y coordinate.
- pix_colour  in  3  pixel colour {R,G,B}.
- fb_busy  in  1  framebuffer port unavailable this cycle; no write may issue.
- fb_we  out  1  framebuffer write strobe, one cycle per write.
- fb_addr  out  15  write address, y*SCREEN_W + x.
- fb_wdata  out  3  write colour.
- clear_req  in  1  single-cycle request to clear the whole screen.
- clear_busy  out  1  high while the clear sequence runs.
- clear_done  out  1  one-cycle pulse after the last clear write.
- pix_dropped  out  16  saturating count of clipped pixels.

Behaviour:
- Reset values: pix_ready 0 while reset is high, then 1 on the first cycle after. fb_we, fb_addr, fb_wdata, clear_busy, clear_done and pix_dropped are all 0. FIFO is emptied and state is DRAIN.
- Push: on pix_valid && pix_ready, {x,y,colour} enters the FIFO.
- pix_ready is registered and equals !full.
- Pushes are never lost; pix_valid without pix_ready has no effect.
- State machine:
  - DRAIN: pop one entry per cycle when FIFO non-empty && !fb_busy.
  - DRAIN -> CLEAR: on clear_req; takes effect the next cycle. Any pop in the same cycle still completes.
  - CLEAR: pops are suspended; pushes continue until full. One write per !fb_busy cycle, address counter 0 .. SCREEN_W*SCREEN_H-1 (0..19199), data BG_COLOUR.
  - CLEAR -> DRAIN: after the write to 19199, clear_done pulses for 1 cycle, clear_busy drops, and draining resumes.
  - clear_req while in CLEAR is ignored.
- Pop latency: an entry popped in cycle N produces fb_we=1 with fb_addr/fb_wdata valid in cycle N+1. fb_we is 0 in every other cycle.
- fb_busy is sampled in the pop/issue cycle. A pixel is never popped unless its write will issue.
- Address arithmetic: fb_addr = (y<<7) + (y<<5) + x, computed at 15 bits. No multiplier.
- Clipping at pop:
  - An entry is clipped if x >= SCREEN_W or y >= SCREEN_H.
  - A clipped entry is consumed with no write, and pix_dropped increments.
  - pix_dropped saturates at 16'hFFFF.
- Boundaries:
  - Full FIFO with a pop this cycle: pix_ready returns to 1 the following cycle.
  - Empty FIFO with a push this cycle: the entry is poppable the next cycle (no fall-through).
- Reset asserted mid-clear or mid-drain: takes effect on the next edge. Sequence aborted, FIFO contents discarded, outputs return to reset values, and clear_done does not pulse.

Optional Feature:
- Macro: PIXEL_DUP_FILTER_EN.
- Defined:
  - The block holds the address and colour of the last issued pixel write, plus a valid flag.
  - A popped pixel whose address and colour both match is consumed with no fb_we and no drop count.
  - The flag clears on reset and on entry to CLEAR.
- Undefined: every in-range popped pixel is written. No extra registers.

Test Plan:
- Reset, then push (x=5, y=3, colour=3'b101) with fb_busy=0 -> fb_we=1 two cycles after the push edge, fb_addr=485, fb_wdata=3'b101; pix_dropped=0.
- Hold fb_busy=1, push 8 pixels -> pix_ready=0 after the 8th accepted push; a 9th pix_valid is not accepted. Release fb_busy -> 8 writes on consecutive cycles in push order, pix_ready=1 the cycle after the first pop.
- Push (x=160, y=0) and (x=0, y=120), then (x=159, y=119, colour=3'b010) -> only one write, fb_addr=19199, data 3'b010; pix_dropped=2.
- Pulse clear_req with 3 pixels queued and fb_busy=0 -> 19200 writes of BG_COLOUR at addresses 0..19199, then clear_done pulses once, then the 3 queued writes follow. A second clear_req mid-clear changes nothing.
- During clear, toggle fb_busy every other cycle -> no address skipped or repeated; total writes remain 19200. Assert reset at address 1000 -> fb_we=0 next cycle, no clear_done, FIFO empty.
- With PIXEL_DUP_FILTER_EN, push (10, 10, 3'b111) twice, then (10, 10, 3'b001) -> exactly 2 writes, both at fb_addr=1610. Without the macro -> 3 writes.

Source files
------------

// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: buffers pixels and writes them to the framebuffer, with clear sequence; optional PIXEL_DUP_FILTER_EN
module pixel_fb_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_x,
  input  logic [6:0]  pix_y,
  input  logic [2:0]  pix_colour,
  input  logic        fb_busy,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_wdata,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [15:0] pix_dropped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LAST = 15'(SCREEN_W * SCREEN_H - 1);
  typedef enum logic {DRAIN, CLEAR} state_t;
  state_t state, state_next;
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count, count_next;
  logic [14:0] clr_addr, haddr;
  logic [7:0] hx;
  logic [6:0] hy;
  logic [2:0] hc;
  logic push, pop, empty, clip, dup, issue_pix, issue_clr, last_clr;
  assign {hx, hy, hc} = mem[rd_ptr[AW-1:0]];
  assign empty = count == '0;
  assign push = pix_valid && pix_ready;
  assign pop = state == DRAIN && !empty && !fb_busy;
  assign clip = 32'(hx) >= SCREEN_W || 32'(hy) >= SCREEN_H;
  assign haddr = ({8'b0, hy} << 7) + ({8'b0, hy} << 5) + {7'b0, hx};
  assign issue_pix = pop && !clip && !dup;
  assign issue_clr = state == CLEAR && !fb_busy;
  assign last_clr = issue_clr && clr_addr == LAST;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
`ifdef PIXEL_DUP_FILTER_EN
  logic dup_valid;
  logic [14:0] dup_addr;
  logic [2:0] dup_col;
  assign dup = dup_valid && dup_addr == haddr && dup_col == hc;
  // remember the last pixel write so identical repeats can be skipped
  always_ff @(posedge clk) begin
    if (reset || (state == DRAIN && state_next == CLEAR)) begin
      dup_valid <= 1'b0;
      dup_addr <= '0;
      dup_col <= '0;
    end else if (issue_pix) begin
      dup_valid <= 1'b1;
      dup_addr <= haddr;
      dup_col <= hc;
    end
  end
`else
  assign dup = 1'b0;
`endif
  // next state: clear request enters CLEAR, last clear write returns to DRAIN
  always_comb begin
    state_next = (state == DRAIN && clear_req) ? CLEAR : last_clr ? DRAIN : state;
  end
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? DRAIN : state_next;
  end
  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {pix_x, pix_y, pix_colour};
  end
  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pix_ready <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
      count <= count_next;
      pix_ready <= count_next != (AW+1)'(FIFO_DEPTH);
    end
  end
  // framebuffer write port, clear counter, status and drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_wdata <= '0;
      clr_addr <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      pix_dropped <= '0;
    end else begin
      fb_we <= issue_pix || issue_clr;
      fb_addr <= issue_clr ? clr_addr : issue_pix ? haddr : fb_addr;
      fb_wdata <= issue_clr ? BG_COLOUR : issue_pix ? hc : fb_wdata;
      clr_addr <= state == DRAIN ? '0 : clr_addr + {14'b0, issue_clr};
      clear_busy <= state_next == CLEAR;
      clear_done <= last_clr;
      pix_dropped <= pix_dropped + {15'b0, pop && clip && pix_dropped != 16'hFFFF};
    end
  end
endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb_pixel_fb_writer: directed bench with a write-sequence scoreboard model
module tb_pixel_fb_writer;
  logic clk = 0, reset = 1, pix_valid = 0, fb_busy = 0, clear_req = 0;
  logic [7:0] pix_x = 0;
  logic [6:0] pix_y = 0;
  logic [2:0] pix_colour = 0;
  logic pix_ready, fb_we, clear_busy, clear_done;
  logic [14:0] fb_addr;
  logic [2:0] fb_wdata;
  logic [15:0] pix_dropped;
  int checks = 0, failures = 0, writes = 0, dones = 0, drops_exp = 0;
  logic [17:0] expq[$];
  logic [17:0] cw;
`ifdef PIXEL_DUP_FILTER_EN
  logic last_valid = 0;
  logic [17:0] last_w = 0;
`endif
  always #5 clk = ~clk;
  pixel_fb_writer dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .fb_busy(fb_busy),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .clear_req(clear_req),
    .clear_busy(clear_busy), .clear_done(clear_done), .pix_dropped(pix_dropped)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  function automatic void model_pix(input int x, input int y, input logic [2:0] c);
    logic [17:0] w;
    if (x >= 160 || y >= 120) begin
      drops_exp++;
      return;
    end
    w = {15'(y * 160 + x), c};
`ifdef PIXEL_DUP_FILTER_EN
    if (last_valid && last_w == w) return;
    last_valid = 1;
    last_w = w;
`endif
    expq.push_back(w);
  endfunction
  function automatic void model_clear();
    for (int a = 0; a < 19200; a++) expq.push_back({15'(a), 3'b000});
`ifdef PIXEL_DUP_FILTER_EN
    last_valid = 0;
`endif
  endfunction
  task automatic push(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    int n = 0;
    @(negedge clk);
    pix_valid = 1; pix_x = x; pix_y = y; pix_colour = c;
    while (!pix_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("push_timeout", 1, 0);
    @(posedge clk);
    #1 pix_valid = 0;
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while (expq.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drained", expq.size(), 0);
  endtask
  task automatic pulse_clear();
    @(negedge clk);
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
  endtask
  // scoreboard: every write must match the next expected one in order
  always @(negedge clk) begin
    if (!reset) begin
      if (fb_we) begin
        writes++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0d/%0d required=none", fb_addr, fb_wdata);
        end else begin
          cw = expq.pop_front();
          check("write_addr_data", {14'b0, fb_addr, fb_wdata}, {14'b0, cw});
        end
      end
      if (clear_done) begin
        dones++;
        check("done_with_last", {16'b0, fb_we, fb_addr}, {16'b0, 1'b1, 15'd19199});
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w0, d0, n;
    repeat (3) @(negedge clk);
    check("rst_ready", pix_ready, 0);
    check("rst_we", fb_we, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_wdata", fb_wdata, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_dropped", pix_dropped, 0);
    reset = 0;
    @(negedge clk);
    check("ready_after_rst", pix_ready, 1);
    model_pix(5, 3, 3'b101);
    push(8'd5, 7'd3, 3'b101);
    @(negedge clk);
    check("t1_pop_cycle_we", fb_we, 0);
    @(negedge clk);
    check("t1_we", fb_we, 1);
    check("t1_addr", fb_addr, 485);
    check("t1_data", fb_wdata, 3'b101);
    check("t1_dropped", pix_dropped, 0);
    fb_busy = 1;
    for (int i = 0; i < 8; i++) begin
      model_pix(i * 3, 7, 3'(i));
      push(8'(i * 3), 7'd7, 3'(i));
    end
    check("full_ready", pix_ready, 0);
    @(negedge clk);
    pix_valid = 1; pix_x = 50; pix_y = 50; pix_colour = 3'b111;
    repeat (4) @(negedge clk);
    check("full_hold_ready", pix_ready, 0);
    pix_valid = 0;
    fb_busy = 0;
    @(negedge clk);
    check("ready_after_pop", pix_ready, 1);
    check("burst_we0", fb_we, 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("burst_we", fb_we, 1);
    end
    @(negedge clk);
    check("burst_end_we", fb_we, 0);
    w0 = writes;
    model_pix(160, 0, 3'b001);
    model_pix(0, 120, 3'b011);
    model_pix(159, 119, 3'b010);
    push(8'd160, 7'd0, 3'b001);
    push(8'd0, 7'd120, 3'b011);
    push(8'd159, 7'd119, 3'b010);
    drain(50);
    check("clip_writes", writes - w0, 1);
    check("clip_last_addr", fb_addr, 19199);
    check("clip_dropped", pix_dropped, 2);
    check("clip_dropped_model", pix_dropped, drops_exp);
    w0 = writes;
    d0 = dones;
    fb_busy = 1;
    push(8'd1, 7'd1, 3'b001);
    push(8'd2, 7'd2, 3'b010);
    push(8'd3, 7'd3, 3'b011);
    model_clear();
    model_pix(1, 1, 3'b001);
    model_pix(2, 2, 3'b010);
    model_pix(3, 3, 3'b011);
    pulse_clear();
    check("clear_busy_high", clear_busy, 1);
    fb_busy = 0;
    repeat (100) @(negedge clk);
    pulse_clear();
    n = 0;
    while (dones == d0 && n < 25000) begin
      @(negedge clk);
      n++;
    end
    check("clear_done_seen", dones - d0, 1);
    check("clear_busy_low", clear_busy, 0);
    drain(50);
    check("clear_done_once", dones - d0, 1);
    check("clear_total_writes", writes - w0, 19203);
    fb_busy = 1;
    push(8'd20, 7'd20, 3'b100);
    push(8'd21, 7'd20, 3'b100);
    model_clear();
    pulse_clear();
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      if (fb_we && fb_addr == 1000) break;
      fb_busy = ~fb_busy;
      n++;
    end
    check("abort_reached_1000", n < 5000, 1);
    d0 = dones;
    reset = 1;
    #1 expq.delete();
`ifdef PIXEL_DUP_FILTER_EN
    last_valid = 0;
`endif
    @(negedge clk);
    check("abort_we", fb_we, 0);
    check("abort_clear_busy", clear_busy, 0);
    check("abort_ready", pix_ready, 0);
    check("abort_dropped", pix_dropped, 0);
    reset = 0;
    fb_busy = 0;
    w0 = writes;
    repeat (10) @(negedge clk);
    check("abort_ready_after", pix_ready, 1);
    check("abort_no_done", dones - d0, 0);
    check("abort_fifo_empty", writes - w0, 0);
    w0 = writes;
    model_pix(10, 10, 3'b111);
    model_pix(10, 10, 3'b111);
    model_pix(10, 10, 3'b001);
    push(8'd10, 7'd10, 3'b111);
    push(8'd10, 7'd10, 3'b111);
    push(8'd10, 7'd10, 3'b001);
    drain(50);
`ifdef PIXEL_DUP_FILTER_EN
    check("dup_writes", writes - w0, 2);
`else
    check("dup_writes", writes - w0, 3);
`endif
    check("dup_addr", fb_addr, 1610);
    check("dup_data", fb_wdata, 3'b001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
